ifetch_buffer: RTL and testbench
================================

Name: ifetch_buffer

Overview:
- Fetch stage directly downstream of the PC register.
- Issues instruction-memory read requests at the current PC and pairs the in-order responses with their PCs.
- Buffers fetched instructions in a small FIFO, presents them to decode with a valid/ready handshake, and back-pressures the PC through pc_stall.
- branch_taken flushes all buffered and in-flight fetches.

Parameters:
- ADDR_W, `INSTR_MEM_WIDTH: PC / instruction address width.
- INSTR_W, 32: instruction width.
- DEPTH, 4: instruction FIFO entries; power of two, >= 2. Also the cap on (occupancy + outstanding).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  ADDR_W  current PC from the PC register.
- pc_stall  out  1  hold PC; high when no request is accepted this cycle.
- branch_taken  in  1  redirect/flush; same signal the PC register consumes.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  fetch address (equals pc_in).
- imem_resp_valid  in  1  response valid; responses in request order, latency >= 1 cycle.
- imem_resp_data  in  INSTR_W  fetched instruction.
- id_valid  out  1  FIFO head valid.
- id_ready  in  1  decode accepts head.
- id_pc  out  ADDR_W  PC of head.
- id_instr  out  INSTR_W  instruction of head.

Behaviour:
- State:
  - instruction FIFO {pc, instr} of DEPTH entries with count;
  - pending-PC FIFO of DEPTH entries holding the addresses of outstanding requests;
  - outstanding counter out_cnt, 0..DEPTH;
  - drop counter drop_cnt, 0..DEPTH.
- Reset: FIFOs empty, out_cnt = drop_cnt = 0, id_valid = 0, imem_req_valid = 0, pc_stall = 1.
- Request issue (combinational):
  - imem_req_valid = !rst && !branch_taken && (count + out_cnt + drop_cnt < DEPTH).
  - imem_req_addr = pc_in.
- Request accept: imem_req_valid && imem_req_ready. The accepted address is pushed to the pending-PC FIFO and out_cnt increments.
- pc_stall = !(imem_req_valid && imem_req_ready). The PC advances by 4 exactly when a request is accepted.
- Response handling:
  - If drop_cnt > 0: the response is discarded and drop_cnt decrements.
  - Otherwise: pop the pending PC and push {pc, data} into the instruction FIFO; out_cnt decrements.
  - The response is never dropped for lack of space; the credit rule guarantees room.
- Decode handshake:
  - id_valid = count != 0; id_pc / id_instr come from the head entry.
  - Pop on id_valid && id_ready.
  - Push and pop may occur in the same cycle; count is unchanged.
  - When the FIFO is empty, a response is not bypassed: it is visible on id_valid the next cycle. Fetch-to-decode latency is therefore memory latency + 1.
- Flush (branch_taken = 1):
  - The instruction FIFO and pending-PC FIFO are cleared.
  - drop_cnt <= drop_cnt + out_cnt − (1 if a response arrives this cycle).
  - out_cnt <= 0.
  - No request is issued that cycle.
  - Any decode pop that cycle is ignored; id outputs next cycle reflect an empty FIFO.
  - Flush has priority over all pushes and pops.
- Back-to-back flushes accumulate correctly in drop_cnt.
- Requests resume the cycle after the flush, at the new pc_in; they may overlap with draining drops and are counted by the credit rule.
- Pointers wrap modulo DEPTH. count and out_cnt are one bit wider than log2(DEPTH).
- Reset mid-operation clears all state regardless of in-flight memory transactions. The memory must also be reset.

Test Plan:
- Reset, then 1-cycle memory always ready, id_ready = 1, pc_in starting at 0x0000 → after reset release requests at 0x0, 0x4, 0x8…; id_valid first high 2 cycles after the first accept with id_pc = 0x0000; thereafter one instruction per cycle in order.
- id_ready = 0 held, DEPTH = 4 → exactly 4 requests accepted, then imem_req_valid = 0 and pc_stall = 1; raising id_ready drains 0x0, 0x4, 0x8, 0xC in order.
- 3-cycle memory latency, 2 requests outstanding (0x10, 0x14), branch_taken pulse with target 0x100 → both stale responses dropped (drop_cnt 2→0); the first id_pc seen after the flush is 0x100.
- imem_req_ready toggling 1,0,1,0 → pc_stall is the inverse of the accept pulse each cycle; no duplicated or skipped PCs at decode.
- Simultaneous response, decode pop and flush in one cycle → FIFO empty next cycle and the arriving response is not counted in drop_cnt.
- rst asserted with FIFO full and 2 outstanding → next cycle id_valid = 0, imem_req_valid = 0, counters 0.

Source files
------------

// File: rtl/ifetch_buffer.sv
// Fetch stage: issues imem reads at pc_in, pairs in-order responses with their PCs,
// buffers them for decode and drains stale responses after a branch flush.
`ifndef INSTR_MEM_WIDTH
`define INSTR_MEM_WIDTH 32
`endif

module ifetch_buffer #(
   parameter int ADDR_W  = `INSTR_MEM_WIDTH,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic               pc_stall,
   input  logic               branch_taken,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [INSTR_W-1:0] id_instr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0]  ipc_q  [DEPTH];
   logic [INSTR_W-1:0] iins_q [DEPTH];
   logic [ADDR_W-1:0]  ppc_q  [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] prd_ptr_q, prd_ptr_d, pwr_ptr_q, pwr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d, out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;

   logic [CNT_W+1:0] credit;
   logic             accept, resp_keep, resp_drop, pop;

   // Occupancy plus everything still in flight (live or stale) bounds new requests,
   // so a returning response always finds room in the instruction FIFO.
   assign credit = {2'b00, count_q} + {2'b00, out_cnt_q} + {2'b00, drop_cnt_q};

   assign imem_req_valid = !rst && !branch_taken && (credit < (CNT_W+2)'(DEPTH));
   assign imem_req_addr  = pc_in;
   assign accept         = imem_req_valid && imem_req_ready;
   assign pc_stall       = !accept;

   assign resp_drop = imem_resp_valid && (drop_cnt_q != '0);
   assign resp_keep = imem_resp_valid && (drop_cnt_q == '0);

   assign id_valid = (count_q != '0);
   assign id_pc    = ipc_q[rd_ptr_q];
   assign id_instr = iins_q[rd_ptr_q];
   assign pop      = id_valid && id_ready;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      prd_ptr_d  = prd_ptr_q;
      pwr_ptr_d  = pwr_ptr_q;
      count_d    = count_q;
      out_cnt_d  = out_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (branch_taken) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         prd_ptr_d  = '0;
         pwr_ptr_d  = '0;
         count_d    = '0;
         out_cnt_d  = '0;
         // A response landing in the flush cycle retires one in-flight slot either way.
         drop_cnt_d = drop_cnt_q + out_cnt_q - CNT_W'(imem_resp_valid);
      end else begin
         if (accept)    pwr_ptr_d = pwr_ptr_q + 1'b1;
         if (resp_keep) begin
            prd_ptr_d = prd_ptr_q + 1'b1;
            wr_ptr_d  = wr_ptr_q + 1'b1;
         end
         if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
         count_d    = count_q + CNT_W'(resp_keep) - CNT_W'(pop);
         out_cnt_d  = out_cnt_q + CNT_W'(accept) - CNT_W'(resp_keep);
         drop_cnt_d = drop_cnt_q - CNT_W'(resp_drop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         prd_ptr_q  <= '0;
         pwr_ptr_q  <= '0;
         count_q    <= '0;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         prd_ptr_q  <= prd_ptr_d;
         pwr_ptr_q  <= pwr_ptr_d;
         count_q    <= count_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         ppc_q[pwr_ptr_q] <= pc_in;
      if (resp_keep && !branch_taken) begin
         ipc_q[wr_ptr_q]  <= ppc_q[prd_ptr_q];
         iins_q[wr_ptr_q] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: in-order memory model, PC register model and
// a queue-based reference of what decode should see.
module tb_ifetch_buffer;

   localparam int AW = 32;
   localparam int IW = 32;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] pc_in;
   logic          pc_stall;
   logic          branch_taken;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [AW-1:0] imem_req_addr;
   logic          imem_resp_valid;
   logic [IW-1:0] imem_resp_data;
   logic          id_valid;
   logic          id_ready;
   logic [AW-1:0] id_pc;
   logic [IW-1:0] id_instr;

   always #5 clk = ~clk;

   ifetch_buffer #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_stall(pc_stall),
      .branch_taken(branch_taken), .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
   );

   typedef struct { logic [31:0] addr; int rdy; bit stale; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

   mreq_t         memq[$];
   ent_t          fifo[$];
   logic [31:0]   pc_reg;
   int            cyc = 0;
   int            last_rdy = 0;
   int            lat_lo = 1, lat_hi = 1;
   int            ncmp = 0, nfail = 0;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit br, input logic [31:0] tgt,
                       input bit idr, input bit rqr);
      bit          rv, exp_rv, acc;
      int          nr;
      mreq_t       m;
      @(negedge clk);
      rst            = r;
      branch_taken   = br;
      id_ready       = idr;
      imem_req_ready = rqr;
      pc_in          = pc_reg;
      rv = !r && memq.size() > 0 && memq[0].rdy <= cyc;
      imem_resp_valid = rv;
      imem_resp_data  = rv ? mdata(memq[0].addr) : $urandom;
      #1;
      exp_rv = !r && !br && (fifo.size() + memq.size() < D);
      acc    = exp_rv && rqr;
      chk("req_valid", imem_req_valid, exp_rv);
      chk("pc_stall", pc_stall, !acc);
      if (exp_rv) chk("req_addr", imem_req_addr, pc_reg);
      chk("id_valid", id_valid, fifo.size() != 0);
      if (fifo.size() != 0) begin
         chk("id_pc", id_pc, fifo[0].pc);
         chk("id_instr", id_instr, fifo[0].instr);
      end
      @(posedge clk);
      if (r) begin
         fifo.delete();
         memq.delete();
         pc_reg   = '0;
         last_rdy = cyc;
      end else if (br) begin
         fifo.delete();
         if (rv) void'(memq.pop_front());
         foreach (memq[i]) memq[i].stale = 1'b1;
         pc_reg = tgt;
      end else begin
         if (fifo.size() != 0 && idr) void'(fifo.pop_front());
         if (rv) begin
            m = memq.pop_front();
            if (!m.stale) fifo.push_back('{pc: m.addr, instr: mdata(m.addr)});
         end
         if (acc) begin
            nr = cyc + $urandom_range(lat_hi, lat_lo);
            if (nr <= last_rdy) nr = last_rdy + 1;
            last_rdy = nr;
            memq.push_back('{addr: pc_reg, rdy: nr, stale: 1'b0});
            pc_reg = pc_reg + 32'd4;
         end
      end
      cyc++;
   endtask

   initial begin
      rst = 1'b1; branch_taken = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_data = '0; pc_reg = '0; pc_in = '0;
      repeat (2) @(posedge clk);

      // reset state, then 1-cycle memory streaming
      step(1, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1);

      // decode stalled: fill to DEPTH, then drain
      step(1, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++)  step(0, 0, 0, 1, 1);

      // 3-cycle memory, two outstanding, then redirect to 0x100
      step(1, 0, 0, 1, 0);
      pc_reg = 32'h10;
      lat_lo = 3; lat_hi = 3;
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 1, 32'h100, 1, 1);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);

      // request-ready toggling
      lat_lo = 1; lat_hi = 2;
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, (i % 2) == 0);

      // response, decode pop and flush together
      lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
      step(0, 1, 32'h200, 1, 1);
      step(0, 1, 32'h300, 1, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);

      // reset with buffered and outstanding work
      lat_lo = 2; lat_hi = 2;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);

      // randomized traffic
      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(199, 0) == 0), ($urandom_range(11, 0) == 0),
              {$urandom_range(16'hFFFF, 0), 2'b00},
              ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
